// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the UART blocks.
//   - uart_tx_state_e : transmitter FSM states. PARITY exists only when
//                       UART_TX_PARITY_EN is defined.
//   - UART_DATA_BITS, UART_DEFAULT_CLKS_PER_BIT : frame constants.
//   - even_parity()   : XOR of the data bits. The result is the bit that
//                       makes the total count of ones even.
//   Optional feature macro: UART_TX_PARITY_EN
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 16;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA,
        PARITY,
        STOP_BIT
    } uart_tx_state_e;
`else
    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA,
        STOP_BIT
    } uart_tx_state_e;
`endif

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// ----------------------------------------------------------------------------
// uart_bit_timer
//   Baud counter that counts 0..CLKS_PER_BIT-1 while enabled and then wraps
//   to 0. tc_o is high during the last cycle of each bit period.
//   Ports:
//     clk    in  system clock, rising edge
//     rst_n  in  asynchronous active-low reset
//     en_i   in  count enable
//     clr_i  in  synchronous clear. It has priority over en_i and holds
//                the count at 0.
//     tc_o   out terminal count. It is qualified by en_i.
// ----------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tc_o = en_i && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = tc_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// ----------------------------------------------------------------------------
// uart_transmitter
//   Sends 8N1 UART frames: one start bit (0), eight data bits with the LSB
//   first, and one stop bit (1). Each bit lasts CLKS_PER_BIT clocks.
//   A one-entry holding register accepts the next byte while a frame is on
//   the line. This lets frames run back to back with no idle gap.
//
//   Ports:
//     clk        in   system clock, rising edge
//     rst        in   asynchronous active-low reset
//     data_in    in   [7:0] byte to send. It is sampled on acceptance.
//     tx_valid   in   host offers data_in
//     tx_ready   out  holding register is empty
//     serial_out out  UART line. It idles high and is driven from a flop.
//     busy       out  a frame is on the line
//     tx_done    out  one-cycle pulse on the final stop-bit cycle
//
//   Handshake: a byte is accepted at a rising edge where tx_valid && tx_ready.
//   When tx_ready is low, tx_valid is ignored. The host then holds data_in and
//   tx_valid until the byte is accepted.
//
//   Optional feature macro: UART_TX_PARITY_EN. When it is defined, an even
//   parity bit is inserted after the data bits, which gives 11-bit frames.
// ----------------------------------------------------------------------------
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] data_in,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic                      serial_out,
    output logic                      busy,
    output logic                      tx_done
);

    localparam int BIT_CNT_W = $clog2(UART_DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_transmitter: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS != UART_DATA_BITS) begin : g_bad_data_bits
        $error("uart_transmitter: DATA_BITS must be 8");
    end

    uart_tx_state_e            state_q, state_d;
    logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] hold_q, hold_d;
    logic                      hold_valid_q, hold_valid_d;
    logic                      serial_q, serial_d;
    logic                      load;
    logic                      tc;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst_n (rst),
        .en_i  (state_q != IDLE),
        .clr_i (state_q == IDLE),
        .tc_o  (tc)
    );

    assign tx_ready   = !hold_valid_q;
    assign serial_out = serial_q;
    assign busy       = (state_q != IDLE);
    assign tx_done    = (state_q == STOP_BIT) && tc;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        serial_d     = serial_q;
        load         = 1'b0;

        // Acceptance and reload never coincide. A reload needs
        // hold_valid_q=1, and acceptance needs hold_valid_q=0.
        if (tx_valid && !hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_d       = data_in;
        end

        case (state_q)
            IDLE: begin
                if (hold_valid_q) begin
                    load = 1'b1;
                end
            end
            START_BIT: begin
                if (tc) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (tc) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP_BIT;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tc) begin
                    state_d = STOP_BIT;
                end
            end
`endif
            STOP_BIT: begin
                // The decision uses the pre-edge hold_valid. A byte that is
                // accepted on this same edge starts after one idle cycle.
                if (tc) begin
                    if (hold_valid_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            state_d      = START_BIT;
            shift_d      = hold_q;
            hold_valid_d = 1'b0;
        end

        // The line level is registered from the next state. This keeps
        // serial_out aligned with state_q and glitch-free.
        case (state_d)
            IDLE:      serial_d = 1'b1;
            START_BIT: serial_d = 1'b0;
            DATA:      serial_d = shift_d[bit_cnt_d];
`ifdef UART_TX_PARITY_EN
            PARITY:    serial_d = even_parity(shift_d);
`endif
            STOP_BIT:  serial_d = 1'b1;
            default:   serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            serial_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            serial_q     <= serial_d;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// ----------------------------------------------------------------------------
// tb_uart_transmitter
//   Bench for uart_transmitter. A line monitor decodes each frame. It checks
//   bit timing, tx_done and busy, and compares the decoded byte with an
//   expected queue that the stimulus fills.
//   Optional feature macro: UART_TX_PARITY_EN (this adds a parity bit to each
//   frame).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_transmitter;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME  = NB * CPB;
    localparam int BUDGET = 4 * FRAME;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       tx_valid;
    logic       tx_ready;
    logic       serial_out;
    logic       busy;
    logic       tx_done;

    uart_transmitter #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .serial_out (serial_out),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : watchdog
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int frames_rx = 0;
    int aborts    = 0;
    int idle_cnt  = 0;
    int last_gap  = 0;
    int busy_cyc  = 0;
    int done_cnt  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (busy === 1'b1)    busy_cyc++;
        if (tx_done === 1'b1) done_cnt++;
    end

    // ---------------- line monitor ----------------
    initial begin : monitor
        logic [10:0] bits;
        logic [7:0]  exp_b;
        int          unstable;
        int          done_err;
        int          busy_err;
        int          b;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                idle_cnt = 0;
            end else if (serial_out === 1'b0) begin
                last_gap = idle_cnt;
                bits     = '0;
                unstable = 0;
                done_err = 0;
                busy_err = 0;
                aborted  = 1'b0;
                for (int s = 0; s < FRAME; s++) begin
                    if (s > 0) @(negedge clk);
                    if (rst !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    b = s / CPB;
                    if ((s % CPB) == 0) bits[b] = serial_out;
                    else if (serial_out !== bits[b]) unstable++;
                    if (tx_done !== ((s == FRAME - 1) ? 1'b1 : 1'b0)) done_err++;
                    if (busy !== 1'b1) busy_err++;
                end
                if (aborted) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    aborts++;
                end else begin
                    frames_rx++;
                    check_eq("frame_expected", (exp_q.size() > 0), 1);
                    exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                    check_eq("rx_data", bits[8:1], exp_b);
                    check_eq("start_bit", bits[0], 0);
`ifdef UART_TX_PARITY_EN
                    check_eq("parity_bit", bits[9], ^exp_b);
`endif
                    check_eq("stop_bit", bits[NB-1], 1);
                    check_eq("bit_stable", unstable, 0);
                    check_eq("tx_done_timing", done_err, 0);
                    check_eq("busy_in_frame", busy_err, 0);
                end
                idle_cnt = 0;
            end else begin
                idle_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Call between edges. The task returns 1ns after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int k = 0;
        data_in  = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        check_eq("send_accept_in_time", (k < BUDGET), 1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        data_in  = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        @(negedge clk);
        while ((busy !== 1'b0 || tx_ready !== 1'b1) && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, (k < BUDGET), 1);
        repeat (3) @(negedge clk);
    endtask

    // ---------------- test sequence ----------------
    initial begin : stim
        int errs;
        int busy_base;
        int done_base;
        int fr_base;
        int ab_base;
        int k;
        logic [7:0] rb;

        rst      = 1'b0;
        tx_valid = 1'b0;
        data_in  = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_serial", serial_out, 1);
        check_eq("rst_ready", tx_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", tx_done, 0);
        rst = 1'b1;

        // Idle period after reset
        errs = 0;
        repeat (100) begin
            @(negedge clk);
            if (serial_out !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) errs++;
        end
        check_eq("idle_100", errs, 0);

        // Single byte 0xA5, including latency from acceptance to the start bit
        busy_base = busy_cyc; done_base = done_cnt; fr_base = frames_rx;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        send_byte(8'hA5);
        @(negedge clk);
        check_eq("lat_e0_line_high", serial_out, 1);
        check_eq("lat_e0_ready_low", tx_ready, 0);
        @(negedge clk);
        check_eq("lat_e1_line_low", serial_out, 0);
        check_eq("lat_e1_busy", busy, 1);
        check_eq("lat_e1_ready", tx_ready, 1);
        wait_idle("single_idle");
        check_eq("single_frames", frames_rx - fr_base, 1);
        check_eq("single_busy_cycles", busy_cyc - busy_base, FRAME);
        check_eq("single_done_pulses", done_cnt - done_base, 1);

        // Back-to-back frames 0x00 then 0xFF
        busy_base = busy_cyc; done_base = done_cnt; fr_base = frames_rx;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_byte(8'h00);
        check_eq("b2b_ready_low", tx_ready, 0);
        send_byte(8'hFF);
        wait_idle("b2b_idle");
        check_eq("b2b_frames", frames_rx - fr_base, 2);
        check_eq("b2b_gap", last_gap, 0);
        check_eq("b2b_busy_cycles", busy_cyc - busy_base, 2 * FRAME);
        check_eq("b2b_done_pulses", done_cnt - done_base, 2);

        // Backpressure: 0x3C is held while the holding register is full
        fr_base = frames_rx;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h3C);
        send_byte(8'h11);
        send_byte(8'h22);
        check_eq("bp_ready_low", tx_ready, 0);
        send_byte(8'h3C);
        wait_idle("bp_idle");
        check_eq("bp_frames", frames_rx - fr_base, 3);
        check_eq("bp_queue_empty", exp_q.size(), 0);

        // Acceptance on the final stop-bit cycle costs one idle cycle
        fr_base = frames_rx;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h07);
        send_byte(8'h5A);
        k = 0;
        @(negedge clk);
        while (tx_done !== 1'b1 && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        check_eq("stop_edge_done_seen", (k < BUDGET), 1);
        send_byte(8'h07);
        wait_idle("stop_edge_idle");
        check_eq("stop_edge_frames", frames_rx - fr_base, 2);
        check_eq("stop_edge_gap", last_gap, 1);

        // Random bytes sent back to back
        fr_base = frames_rx;
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom_range(0, 255));
            exp_q.push_back(rb);
            send_byte(rb);
        end
        wait_idle("rand_idle");
        check_eq("rand_frames", frames_rx - fr_base, 4);

        // Reset asserted in the middle of the data bits of 0x81
        fr_base = frames_rx; ab_base = aborts;
        exp_q.push_back(8'h81);
        send_byte(8'h81);
        repeat (3 * CPB) @(negedge clk);
        check_eq("mid_busy_before_rst", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_serial", serial_out, 1);
        check_eq("mid_rst_ready", tx_ready, 1);
        check_eq("mid_rst_busy", busy, 0);
        @(negedge clk);
        #3;
        rst = 1'b1;
        errs = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (serial_out !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) errs++;
        end
        check_eq("post_rst_quiet", errs, 0);
        check_eq("post_rst_no_frame", frames_rx - fr_base, 0);
        check_eq("post_rst_abort", aborts - ab_base, 1);

        check_eq("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
